// File: rtl/rc4_plaintext_checker.sv
// rc4_plaintext_checker
//
// Judges whole decrypted messages coming out of the RC4 decrypt loop. For
// each key in the window [key_base, key_limit] it requests a fresh decrypt
// (key_req), then accepts MSG_LEN bytes one at a time. Each byte must lie in
// [LO_CHAR, HI_CHAR], or be 8'h20 when ALLOW_SPACE is set. The first invalid
// byte abandons the key and steps to the next one. A key whose bytes all pass
// is reported through found/found_key. Running off the end of the window
// raises exhausted.
//
// Ports
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   start          : begins a search (honoured in IDLE, FOUND and EXHAUST)
//   key_base       : first key of the window (sampled at start)
//   key_limit      : last key of the window, inclusive (sampled at start)
//   byte_in        : decrypted byte from the RC4 core
//   byte_vld       : byte_in valid; a transfer happens on byte_vld && byte_rdy
//   byte_rdy       : checker accepts a byte this cycle
//   cur_key        : key under test, drives the RC4 core
//   key_req        : one-cycle pulse, RC4 core restarts with cur_key
//   byte_idx       : index of the next byte expected
//   busy           : search in progress
//   found          : sticky, a fully valid message was found
//   exhausted      : sticky, window ended without a valid key
//   found_key      : key that produced the valid message
//
// Optional build macro CHECKER_STATS_EN adds:
//   keys_tried     : keys judged since start, counting the successful one
//   bytes_checked  : saturating count of bytes accepted since start
module rc4_plaintext_checker #(
  parameter int         MSG_LEN     = 32,
  parameter int         KEY_W       = 24,
  parameter logic [7:0] LO_CHAR     = 8'h61,
  parameter logic [7:0] HI_CHAR     = 8'h7A,
  parameter bit         ALLOW_SPACE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_base,
  input  logic [KEY_W-1:0] key_limit,
  input  logic [7:0]       byte_in,
  input  logic             byte_vld,
  output logic             byte_rdy,
  output logic [KEY_W-1:0] cur_key,
  output logic             key_req,
  output logic [7:0]       byte_idx,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W-1:0] found_key
`ifdef CHECKER_STATS_EN
  ,
  output logic [KEY_W:0]   keys_tried,
  output logic [31:0]      bytes_checked
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    KREQ,
    WAIT_BYTE,
    CHECK,
    NEXT_KEY,
    FOUND,
    EXHAUST
  } state_t;

  localparam logic [7:0]       LAST_IDX = 8'(MSG_LEN - 1);
  localparam logic [KEY_W-1:0] KEY_ONE  = KEY_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [KEY_W-1:0] limit;
  logic [7:0]       byte_p1;
  logic             xfer;
  logic             idle_like;
  logic             chk_ok;
  logic             chk_last;
  logic             key_done;

  function automatic logic byte_ok(input logic [7:0] b);
    logic in_range;
    logic is_space;
    in_range = (b >= LO_CHAR) && (b <= HI_CHAR);
    is_space = ALLOW_SPACE && (b == 8'h20);
    return in_range || is_space;
  endfunction

  assign idle_like = (state == IDLE) || (state == FOUND) || (state == EXHAUST);
  assign byte_rdy  = (state == WAIT_BYTE);
  assign key_req   = (state == KREQ);
  assign busy      = !idle_like;
  assign xfer      = byte_rdy && byte_vld;
  assign chk_ok    = byte_ok(byte_p1);
  assign chk_last  = (byte_idx == LAST_IDX);
  // ">=" rather than "==" so a window with key_base > key_limit collapses to
  // the single key key_base instead of sweeping up to all-ones.
  assign key_done  = (cur_key >= limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FOUND, EXHAUST: if (start) state_nx = KREQ;
      KREQ:                 state_nx = WAIT_BYTE;
      WAIT_BYTE:            if (byte_vld) state_nx = CHECK;
      CHECK: begin
        if (!chk_ok)       state_nx = NEXT_KEY;
        else if (chk_last) state_nx = FOUND;
        else               state_nx = WAIT_BYTE;
      end
      NEXT_KEY:             state_nx = key_done ? EXHAUST : KREQ;
      default:              state_nx = IDLE;
    endcase
  end

  // Byte capture: accepted at the WAIT_BYTE edge, judged in CHECK one edge later.
  always_ff @(posedge clk) begin
    if (xfer) byte_p1 <= byte_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_key   <= '0;
      limit     <= '0;
      byte_idx  <= '0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      found_key <= '0;
    end else begin
      case (state)
        IDLE, FOUND, EXHAUST: begin
          if (start) begin
            cur_key   <= key_base;
            limit     <= key_limit;
            found     <= 1'b0;
            exhausted <= 1'b0;
          end
        end
        KREQ: byte_idx <= '0;
        CHECK: begin
          if (chk_ok && chk_last) begin
            found_key <= cur_key;
            found     <= 1'b1;
          end else if (chk_ok) begin
            byte_idx <= byte_idx + 8'd1;
          end
        end
        NEXT_KEY: begin
          if (key_done) exhausted <= 1'b1;
          else          cur_key   <= cur_key + KEY_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef CHECKER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_tried    <= '0;
      bytes_checked <= '0;
    end else begin
      if (idle_like && start) begin
        keys_tried    <= '0;
        bytes_checked <= '0;
      end else begin
        if ((state == NEXT_KEY) || ((state == CHECK) && chk_ok && chk_last))
          keys_tried <= keys_tried + (KEY_W+1)'(1);
        if (xfer && (bytes_checked != 32'hFFFF_FFFF))
          bytes_checked <= bytes_checked + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rc4_plaintext_checker.sv
module tb_rc4_plaintext_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [23:0] key_base, key_limit;
  logic [7:0]  byte_in;
  logic        byte_vld;

  logic        a_rdy, a_req, a_busy, a_found, a_exh;
  logic [23:0] a_cur, a_fk;
  logic [7:0]  a_idx;
  logic        b_rdy, b_req, b_busy, b_found, b_exh;
  logic [23:0] b_cur, b_fk;
  logic [7:0]  b_idx;
`ifdef CHECKER_STATS_EN
  logic [24:0] a_kt, b_kt;
  logic [31:0] a_bc, b_bc;
`endif

  // Selected DUT view
  logic        sel;
  logic        o_rdy, o_req, o_busy, o_found, o_exh;
  logic [23:0] o_cur, o_fk;
  logic [7:0]  o_idx;

  int n_chk  = 0;
  int n_fail = 0;

  logic [23:0] exp_q[$];

  initial forever #5 clk = ~clk;

  rc4_plaintext_checker dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .key_base(key_base), .key_limit(key_limit),
    .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(a_rdy),
    .cur_key(a_cur), .key_req(a_req), .byte_idx(a_idx), .busy(a_busy),
    .found(a_found), .exhausted(a_exh), .found_key(a_fk)
`ifdef CHECKER_STATS_EN
    , .keys_tried(a_kt), .bytes_checked(a_bc)
`endif
  );

  rc4_plaintext_checker #(.MSG_LEN(4), .ALLOW_SPACE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .key_base(key_base), .key_limit(key_limit),
    .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(b_rdy),
    .cur_key(b_cur), .key_req(b_req), .byte_idx(b_idx), .busy(b_busy),
    .found(b_found), .exhausted(b_exh), .found_key(b_fk)
`ifdef CHECKER_STATS_EN
    , .keys_tried(b_kt), .bytes_checked(b_bc)
`endif
  );

  always_comb begin
    o_rdy   = sel ? b_rdy   : a_rdy;
    o_req   = sel ? b_req   : a_req;
    o_busy  = sel ? b_busy  : a_busy;
    o_found = sel ? b_found : a_found;
    o_exh   = sel ? b_exh   : a_exh;
    o_cur   = sel ? b_cur   : a_cur;
    o_fk    = sel ? b_fk    : a_fk;
    o_idx   = sel ? b_idx   : a_idx;
  end

  // Byte stream produced by the stand-in RC4 core for a given scenario/key.
  function automatic logic [7:0] gen(input int scen, input logic [23:0] k, input int idx);
    logic [7:0] r;
    r = 8'h00;
    case (scen)
      0: if (k == 24'h10) r = 8'h61 + 8'(idx % 26);
      1: begin
        if (k == 24'h10)      r = (idx == 5) ? 8'h7B : 8'h61 + 8'(idx % 26);
        else if (k == 24'h11) r = 8'h71;
      end
      2: begin
        if (k == 24'h30)      r = (idx == 3) ? 8'h20 : 8'h62;
        else if (k == 24'h31) r = 8'h63;
      end
      4: if (k == 24'h23) r = 8'h61;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic ref_ok(input logic [7:0] b, input logic sp);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (sp && (b == 8'h20));
  endfunction

  // Scoreboard engine: predicts the key_req sequence, drives a search and a
  // holding byte producer, and checks every key_req and byte transfer.
  task automatic run_search(input logic s, input int scen, input logic [23:0] base,
                            input logic [23:0] lim, input int poke_cyc,
                            output int cycles, output int nreq, output int nbytes);
    int          mlen;
    logic        sp, bad, done;
    logic [23:0] k, pk, ek;
    int          pidx;
    sel  = s;
    mlen = s ? 4 : 32;
    sp   = !s;
    k    = base;
    exp_q.delete();
    for (int g = 0; g < 300; g++) begin
      exp_q.push_back(k);
      bad = 1'b0;
      for (int i = 0; i < mlen; i++)
        if (!ref_ok(gen(scen, k, i), sp)) begin bad = 1'b1; break; end
      if (!bad || (k >= lim)) break;
      k = k + 24'd1;
    end
    @(negedge clk);
    key_base  = base;
    key_limit = lim;
    byte_vld  = 1'b0;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    pk = '0; pidx = 0; nreq = 0; nbytes = 0; cycles = 0; done = 1'b0;
    for (int cyc = 0; cyc <= 20000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == poke_cyc) begin
        key_base = 24'h40;
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (o_req) begin
        nreq++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL key_req_extra: got unexpected key_req with cur_key %0h", o_cur);
        end else begin
          ek = exp_q.pop_front();
          if (o_cur !== ek) begin
            n_fail++;
            $display("FAIL key_req_key: got cur_key %0h expected %0h", o_cur, ek);
          end
        end
        pk = o_cur;
        pidx = 0;
      end
      byte_in  = gen(scen, pk, pidx);
      byte_vld = 1'b1;
      if (o_rdy) begin
        n_chk++;
        if (o_idx !== 8'(pidx)) begin
          n_fail++;
          $display("FAIL byte_idx: got %0d expected %0d (key %0h)", o_idx, pidx, pk);
        end
        pidx++;
        nbytes++;
      end
      if (o_found || o_exh) begin
        cycles = cyc;
        done = 1'b1;
        break;
      end
    end
    byte_vld = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL search_timeout: got no terminal state expected found or exhausted");
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL key_req_missing: got %0d keys unrequested expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; byte_vld = 1'b0;
    byte_in = 8'h00; key_base = '0; key_limit = '0; sel = 1'b0;
    #1;
    n_chk++;
    if ({o_rdy, o_req, o_busy, o_found, o_exh} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {o_rdy, o_req, o_busy, o_found, o_exh});
    end
    n_chk++;
    if ({o_cur, o_fk, o_idx} !== 56'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %0h/%0h/%0h expected 0/0/0", o_cur, o_fk, o_idx);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_found_first;
    int cyc, nr, nb;
    run_search(1'b0, 0, 24'h10, 24'hFF, -1, cyc, nr, nb);
    n_chk++;
    if (o_found !== 1'b1 || o_exh !== 1'b0) begin
      n_fail++;
      $display("FAIL first_found: got found %b exhausted %b expected 1 0", o_found, o_exh);
    end
    n_chk++;
    if (o_fk !== 24'h10) begin
      n_fail++;
      $display("FAIL first_found_key: got %0h expected 10", o_fk);
    end
    n_chk++;
    if (nr != 1) begin
      n_fail++;
      $display("FAIL first_key_req_count: got %0d expected 1", nr);
    end
    n_chk++;
    if (cyc != 65 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL first_latency: got %0d cycles busy %b expected 65 cycles busy 0", cyc, o_busy);
    end
    n_chk++;
    if (nb != 32) begin
      n_fail++;
      $display("FAIL first_bytes: got %0d expected 32", nb);
    end
  endtask

  task automatic test_key_advance;
    int cyc, nr, nb;
    run_search(1'b0, 1, 24'h10, 24'hFF, -1, cyc, nr, nb);
    n_chk++;
    if (o_found !== 1'b1 || o_fk !== 24'h11) begin
      n_fail++;
      $display("FAIL advance_found_key: got found %b key %0h expected 1 11", o_found, o_fk);
    end
    n_chk++;
    if (nr != 2 || o_cur !== 24'h11) begin
      n_fail++;
      $display("FAIL advance_key_req: got %0d reqs cur_key %0h expected 2 11", nr, o_cur);
    end
  endtask

  task automatic test_space;
    int cyc, nr, nb;
    run_search(1'b0, 2, 24'h30, 24'h31, -1, cyc, nr, nb);
    n_chk++;
    if (o_found !== 1'b1 || o_fk !== 24'h30 || nr != 1) begin
      n_fail++;
      $display("FAIL space_allowed: got found %b key %0h reqs %0d expected 1 30 1", o_found, o_fk, nr);
    end
    run_search(1'b1, 2, 24'h30, 24'h31, -1, cyc, nr, nb);
    n_chk++;
    if (o_found !== 1'b1 || o_fk !== 24'h31 || nr != 2) begin
      n_fail++;
      $display("FAIL space_rejected: got found %b key %0h reqs %0d expected 1 31 2", o_found, o_fk, nr);
    end
    n_chk++;
    if (nb != 8) begin
      n_fail++;
      $display("FAIL space_rejected_bytes: got %0d expected 8", nb);
    end
  endtask

  task automatic test_exhaust;
    int cyc, nr, nb;
    run_search(1'b0, 3, 24'h05, 24'h05, -1, cyc, nr, nb);
    n_chk++;
    if (o_exh !== 1'b1 || o_found !== 1'b0 || o_cur !== 24'h05 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust_single: got exh %b found %b key %0h busy %b expected 1 0 5 0",
               o_exh, o_found, o_cur, o_busy);
    end
    run_search(1'b0, 3, 24'h09, 24'h03, -1, cyc, nr, nb);
    n_chk++;
    if (o_exh !== 1'b1 || o_found !== 1'b0 || o_cur !== 24'h09 || nr != 1) begin
      n_fail++;
      $display("FAIL exhaust_inverted: got exh %b found %b key %0h reqs %0d expected 1 0 9 1",
               o_exh, o_found, o_cur, nr);
    end
  endtask

  task automatic test_reset_midsearch;
    int cyc, nr, nb;
    logic hit;
    sel = 1'b0;
    hit = 1'b0;
    @(negedge clk);
    key_base = 24'h10; key_limit = 24'hFF; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    byte_in = 8'h61; byte_vld = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (o_rdy && o_idx == 8'd7) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midsearch_reach: got no WAIT_BYTE at byte_idx 7 expected one");
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({o_rdy, o_req, o_busy, o_found, o_exh} !== 5'b0 || {o_cur, o_fk, o_idx} !== 56'h0) begin
      n_fail++;
      $display("FAIL midsearch_reset: got flags %b key %0h fk %0h idx %0h expected all 0",
               {o_rdy, o_req, o_busy, o_found, o_exh}, o_cur, o_fk, o_idx);
    end
    byte_vld = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_search(1'b0, 0, 24'h10, 24'hFF, -1, cyc, nr, nb);
    n_chk++;
    if (o_found !== 1'b1 || o_fk !== 24'h10 || nr != 1) begin
      n_fail++;
      $display("FAIL midsearch_restart: got found %b key %0h reqs %0d expected 1 10 1", o_found, o_fk, nr);
    end
  endtask

  task automatic test_start_ignored;
    int cyc, nr, nb;
    run_search(1'b0, 0, 24'h10, 24'hFF, 10, cyc, nr, nb);
    n_chk++;
    if (o_found !== 1'b1 || o_fk !== 24'h10 || nr != 1 || cyc != 65) begin
      n_fail++;
      $display("FAIL start_while_busy: got found %b key %0h reqs %0d cycles %0d expected 1 10 1 65",
               o_found, o_fk, nr, cyc);
    end
  endtask

  task automatic test_stats;
`ifdef CHECKER_STATS_EN
    int cyc, nr, nb;
    run_search(1'b1, 4, 24'h20, 24'h30, -1, cyc, nr, nb);
    n_chk++;
    if (o_fk !== 24'h23 || b_kt !== 25'd4) begin
      n_fail++;
      $display("FAIL stats_keys_tried: got key %0h keys_tried %0d expected 23 4", o_fk, b_kt);
    end
    n_chk++;
    if (b_bc !== 32'd7) begin
      n_fail++;
      $display("FAIL stats_bytes_checked: got %0d expected 7", b_bc);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int cyc, nr, nb;
    // A new search launched straight from EXHAUST on the short-message instance.
    run_search(1'b1, 3, 24'h07, 24'h08, -1, cyc, nr, nb);
    n_chk++;
    if (o_exh !== 1'b1 || o_cur !== 24'h08 || nr != 2) begin
      n_fail++;
      $display("FAIL b2b_exhaust: got exh %b key %0h reqs %0d expected 1 8 2", o_exh, o_cur, nr);
    end
    run_search(1'b1, 2, 24'h31, 24'h31, -1, cyc, nr, nb);
    n_chk++;
    if (o_found !== 1'b1 || o_exh !== 1'b0 || o_fk !== 24'h31 || cyc != 9) begin
      n_fail++;
      $display("FAIL b2b_found: got found %b exh %b key %0h cycles %0d expected 1 0 31 9",
               o_found, o_exh, o_fk, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_found_first();
    test_key_advance();
    test_space();
    test_exhaust();
    test_reset_midsearch();
    test_start_ignored();
    test_stats();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
